uart_rx_sequencer: RTL

Receive-side frame sequencer for the UART block. It oversamples the serial line, detects and qualifies start bits, and times the sampling of data, parity and stop bits. It assembles the received word, flags framing, break, parity and overflow errors, and issues a single write strobe per accepted frame toward the receive FIFO. It replaces ad-hoc counter/shift control in the receiver datapath with one self-contained FSM.

---
 rtl/uart_rx_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer
//   Receive-side frame sequencer for the UART. It oversamples rx_in, qualifies
//   start bits at mid-bit, times the data/parity/stop samples, assembles the
//   word LSB first and issues one FIFO write strobe per accepted frame.
//
//   Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and the
//   parity_error flag; without it parity_error is tied low and parity_odd is
//   ignored).
//
// Ports
//   clk            oversampling clock (OVERSAMPLE x baud)
//   reset_n        asynchronous active-low reset
//   rx_in          raw serial line, idle high
//   fifo_full      receive FIFO full; a frame arriving while high is dropped
//   err_clear      one-cycle pulse clearing all sticky error flags
//   parity_odd     1 = odd parity, 0 = even (parity build only)
//   shift_en       one-cycle pulse at each data-bit sample
//   frame_valid    one-cycle FIFO write strobe
//   rx_data        last accepted word
//   busy           high whenever the FSM is out of IDLE
//   parity_error, stop_error, break_error, overflow_error   sticky flags
module uart_rx_sequencer #(
   parameter int DATA_SIZE  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx_in,
   input  logic                 fifo_full,
   input  logic                 err_clear,
   input  logic                 parity_odd,
   output logic                 shift_en,
   output logic                 frame_valid,
   output logic [DATA_SIZE-1:0] rx_data,
   output logic                 busy,
   output logic                 parity_error,
   output logic                 stop_error,
   output logic                 break_error,
   output logic                 overflow_error
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_SIZE + 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_PARITY     = 3'd3,
      S_STOP       = 3'd4,
      S_BREAK_WAIT = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_STOP       = 3'd4,
      S_BREAK_WAIT = 3'd5
   } state_t;
`endif

   state_t               state, state_nxt;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_SIZE-1:0] shreg;
   logic                 samp;

   // event strobes decoded in the output process, registered into flags
   logic                 stop_smp;
   logic                 brk_evt;
   logic                 stop_err_evt;
   logic                 wr_evt;
   logic                 ovf_evt;

   // 2-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], rx_in};
   end
   assign rx_s = sync_q[1];

   // mid-bit sample point for DATA, PARITY and STOP
   assign samp = (cnt == CNT_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (!rx_s) state_nxt = S_START;
         S_START:      if (cnt == CNT_HALF) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (samp && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY:     if (samp) state_nxt = S_STOP;
`endif
         S_STOP: begin
            // a low stop bit over an all-zero word is a break: hold until
            // the line recovers; otherwise re-arm at mid-stop-bit
            if (samp) state_nxt = (!rx_s && shreg == '0) ? S_BREAK_WAIT : S_IDLE;
         end
         S_BREAK_WAIT: if (rx_s) state_nxt = S_IDLE;
         default:      state_nxt = S_IDLE;
      endcase
   end

   // ---------------- outputs / event decode ----------------
   always_comb begin
      shift_en     = 1'b0;
      busy         = (state != S_IDLE);
      stop_smp     = 1'b0;
      brk_evt      = 1'b0;
      stop_err_evt = 1'b0;
      wr_evt       = 1'b0;
      ovf_evt      = 1'b0;
      if (state == S_DATA && samp) shift_en = 1'b1;
      if (state == S_STOP && samp) begin
         stop_smp     = 1'b1;
         stop_err_evt = !rx_s;
         brk_evt      = !rx_s && (shreg == '0);
         wr_evt       = !brk_evt && !fifo_full;
         ovf_evt      = !brk_evt && fifo_full;
      end
   end

   // ---------------- counters and shift register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            S_START: begin
               cnt     <= (cnt == CNT_HALF) ? '0 : cnt + 1'b1;
               bit_cnt <= '0;
            end
            S_DATA: begin
               cnt <= samp ? '0 : cnt + 1'b1;
               if (samp) begin
                  shreg   <= {rx_s, shreg[DATA_SIZE-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: cnt <= samp ? '0 : cnt + 1'b1;
`endif
            S_STOP:   cnt <= samp ? '0 : cnt + 1'b1;
            default:  cnt <= '0;
         endcase
      end
   end

   // ---------------- write strobe, data and sticky flags ----------------
   // a set event in the same cycle as err_clear takes priority
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_valid    <= 1'b0;
         rx_data        <= '0;
         stop_error     <= 1'b0;
         break_error    <= 1'b0;
         overflow_error <= 1'b0;
      end else begin
         frame_valid <= wr_evt;
         if (wr_evt) rx_data <= shreg;

         if (stop_err_evt)   stop_error <= 1'b1;
         else if (err_clear) stop_error <= 1'b0;

         if (brk_evt)        break_error <= 1'b1;
         else if (err_clear) break_error <= 1'b0;

         if (ovf_evt)        overflow_error <= 1'b1;
         else if (err_clear) overflow_error <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_err_evt;
   assign par_err_evt = (state == S_PARITY) && samp && (rx_s != ((^shreg) ^ parity_odd));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         parity_error <= 1'b0;
      else if (par_err_evt) parity_error <= 1'b1;
      else if (err_clear)   parity_error <= 1'b0;
   end
`else
   logic unused_parity_odd;
   assign unused_parity_odd = parity_odd;
   assign parity_error      = 1'b0;
`endif

   // stop_smp is kept as a named decode point for debug visibility
   logic unused_stop_smp;
   assign unused_stop_smp = stop_smp;

endmodule
